// File: rtl/fp_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_accel_pkg
//  Description : Shared fp32 widths and constants for the FP accelerator units
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_accel_pkg;
    localparam int          FP32_W        = 32;
    localparam logic [31:0] FP32_POS_ZERO = 32'h00000000;
    localparam logic [31:0] FP32_NEG_ZERO = 32'h80000000;
    localparam logic [31:0] FP32_ONE      = 32'h3F800000;
endpackage
`default_nettype wire

// File: rtl/IEEE_754_Adder.sv
`default_nettype none
// ============================================================================
//  Module      : IEEE_754_Adder
//  Description : Combinational fp32 adder. Subnormal inputs are treated as
//                zero, results with exponent <= 105 flush to +0, overflow
//                saturates to signed infinity, fraction bits are truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module IEEE_754_Adder
    import fp_accel_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    logic               w_a_big;
    logic [31:0]        w_l;
    logic [31:0]        w_s;
    logic [7:0]         w_shift;
    logic [23:0]        w_ml;
    logic [23:0]        w_ms;
    logic [24:0]        w_mag;
    logic signed [9:0]  w_exp;

    // Align the smaller magnitude to the larger, add/subtract, renormalise and pack.
    always_comb begin
        w_a_big = (i_a[30:0] >= i_b[30:0]);
        w_l     = w_a_big ? i_a : i_b;
        w_s     = w_a_big ? i_b : i_a;
        w_shift = w_l[30:23] - w_s[30:23];
        w_ml    = {1'b1, w_l[22:0]};
        w_ms    = (w_shift > 8'd23) ? 24'd0 : ({1'b1, w_s[22:0]} >> w_shift);
        w_exp   = $signed({2'b00, w_l[30:23]});
        if (w_l[31] == w_s[31]) begin
            w_mag = {1'b0, w_ml} + {1'b0, w_ms};
        end else begin
            w_mag = {1'b0, w_ml} - {1'b0, w_ms};
        end
        if (w_mag[24]) begin
            w_mag = w_mag >> 1;
            w_exp = w_exp + 10'sd1;
        end else begin
            for (int k = 0; k < 23; k++) begin
                if (!w_mag[23] && (w_mag != 25'd0)) begin
                    w_mag = w_mag << 1;
                    w_exp = w_exp - 10'sd1;
                end
            end
        end

        // Zero operands pass the other operand through; 0 + 0 is -0 only if both are -0.
        if ((i_a[30:23] == 8'd0) && (i_b[30:23] == 8'd0)) begin
            o_sum = {i_a[31] & i_b[31], 31'd0};
        end else if (i_a[30:23] == 8'd0) begin
            o_sum = i_b;
        end else if (i_b[30:23] == 8'd0) begin
            o_sum = i_a;
        end else if (w_mag == 25'd0) begin
            o_sum = FP32_POS_ZERO;
        end else if (w_exp >= 10'sd255) begin
            o_sum = {w_l[31], 8'hFF, 23'd0};
        end else if (w_exp <= 10'sd105) begin
            o_sum = FP32_POS_ZERO;
        end else begin
            o_sum = {w_l[31], w_exp[7:0], w_mag[22:0]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Combinational one-hot grant scanning
//                upward from the last winner; pointer moves only on a grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic [IDX_W-1:0] r_last_grant;
    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // First requester after the last winner wins; nothing is granted while disabled.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(r_last_grant) + k) % N);
            if (!w_found && en && req[w_cand]) begin
                w_found        = 1'b1;
                grant[w_cand]  = 1'b1;
                grant_idx      = w_cand;
            end
        end
    end

    // Remember the winner so it becomes lowest priority next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= IDX_W'(N - 1);
        end else if (en && (|req)) begin
            r_last_grant <= grant_idx;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fp_adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fp_adder_rr_scheduler
//  Description : Shares one fp32 adder among NUM_REQ requesters with
//                round-robin grant and a 2-stage valid/ready pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_adder_rr_scheduler
    import fp_accel_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FP32_W-1:0] req_a,
    input  logic [NUM_REQ*FP32_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [FP32_W-1:0]         rsp_sum,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);
    logic              r_s1_valid;
    logic [FP32_W-1:0] r_s1_a;
    logic [FP32_W-1:0] r_s1_b;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_s2_valid;
    logic [FP32_W-1:0] r_s2_sum;
    logic [ID_W-1:0]   r_s2_id;

    logic               w_s2_free;
    logic               w_s1_adv;
    logic               w_s1_free;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic [FP32_W-1:0]  w_op_a;
    logic [FP32_W-1:0]  w_op_b;
    logic [FP32_W-1:0]  w_sum;

    assign w_s2_free = !r_s2_valid || rsp_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign w_s1_free = !r_s1_valid || w_s1_adv;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .en        (w_s1_free),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Select the granted requester's operands.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_grant_idx) begin
                w_op_a = req_a[i*FP32_W +: FP32_W];
                w_op_b = req_b[i*FP32_W +: FP32_W];
            end
        end
    end

    IEEE_754_Adder u_add (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_sum (w_sum)
    );

    // S1 captures the granted operands, or empties when its add moves to S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
        end else if (|w_grant) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= w_op_a;
            r_s1_b     <= w_op_b;
            r_s1_id    <= w_grant_idx;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 holds the result until taken; drain and refill may share one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_id    <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_sum   <= w_sum;
            r_s2_id    <= r_s1_id;
        end else if (rsp_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_s2_valid;
    assign rsp_sum   = r_s2_sum;
    assign rsp_id    = r_s2_id;
    assign busy      = r_s1_valid || r_s2_valid;
endmodule
`default_nettype wire
